ff_init_ctrl: RTL and testbench
===============================

Name: ff_init_ctrl

Overview:
- Initialisation sequencer for a bank of WIDTH negedge flops with async active-low reset/set, i.e. dffnrs instances.
- Drives each flop's reset and set pins to force a programmable power-on value, holds it, then releases the bank group-by-group so release edges are staggered.
- Sits between the system reset/boot logic and any register bank built from set/reset flops.
- Controller logic runs on posedge clk, so every output change lands a half-cycle away from the bank's negedge sampling.

Parameters:
- WIDTH, 8: number of controlled flops.
- GROUP, 2: flops released per cycle. WIDTH must be a multiple of GROUP; NGRP = WIDTH/GROUP.
- HOLD, 4: cycles the init value is forced before release begins. Must be ≥1.

Ports:
- clk, in, 1: clock; all controller state updates on posedge.
- R, in, 1: reset, asynchronous, active-low. This is fixed.
- start, in, 1: begin an init sequence. Sampled only in IDLE or DONE.
- abort, in, 1: synchronous abort; returns the bank to held-reset.
- init_val, in, WIDTH: value to force. Captured on the accepted start.
- rst_n_o, out, WIDTH: per-flop active-low reset, to flop R.
- set_n_o, out, WIDTH: per-flop active-low set, to flop S.
- busy, out, 1: high in ASSERT and RELEASE.
- done, out, 1: level, high in DONE.

Behaviour:
- All outputs are registered.
- R low, asynchronously:
  - state=IDLE
  - rst_n_o=0 (all bits), set_n_o=all 1s
  - busy=0, done=0
  - counters=0, captured value=0
- IDLE: bank held in reset (rst_n_o=0, set_n_o=1s). A start=1 at a posedge moves to ASSERT.
- Accepting start at edge k:
  - latch v=init_val.
  - From edge k, per bit i: if v[i]=1 then rst_n_o[i]=1, set_n_o[i]=0; otherwise rst_n_o[i]=0, set_n_o[i]=1.
  - busy=1, hold counter loaded with HOLD-1.
- ASSERT: counter decrements each edge. When it is 0, the next edge (k+HOLD) enters RELEASE and releases group 0.
- RELEASE:
  - Group g = bits [g*GROUP +: GROUP], released at edge k+HOLD+g.
  - Released bits have rst_n_o=1 and set_n_o=1. Unreleased bits keep their ASSERT values.
  - Groups are released LSB group first.
- DONE:
  - Entered at edge k+HOLD+NGRP: busy=0, done=1.
  - All rst_n_o and set_n_o are 1.
  - Total busy time is exactly HOLD+NGRP cycles.
- Invariant: rst_n_o[i] and set_n_o[i] are never both 0, in any state or during reset.
- start while busy: ignored. init_val is not re-sampled.
- start in DONE: new sequence with the same timing as from IDLE. done drops at the accepting edge.
- abort=1 at any posedge in ASSERT, RELEASE or DONE:
  - next state IDLE, outputs return to the held-reset values, busy=0, done=0.
  - abort takes priority over start in the same cycle.
- abort in IDLE: no effect, and start is blocked that cycle.
- R asserted mid-sequence: immediate async return to the reset values. No partial release survives.
- HOLD=1: release of group 0 happens at edge k+1.
- NGRP=1: the whole bank releases in a single edge.

Decomposition:
- Package ff_init_pkg holds:
  - state enum {IDLE, ASSERT, RELEASE, DONE}
  - function clog2
  - localparam helpers for counter widths: HCW=clog2(HOLD), GCW=clog2(NGRP)
- One natural sub-module, ff_init_cnt: a loadable down-counter with a zero flag. It is instantiated twice, once for the hold count and once for the group index.
- Output mask generation (group-release mask ANDed with v) stays in the top level.

Test Plan (WIDTH=8, GROUP=2, HOLD=4):
- Reset then idle: R low → rst_n_o=0x00, set_n_o=0xFF, busy=0, done=0. After R rises these values are held until start.
- Normal init, init_val=0xA5, start at edge k:
  - edges k..k+3: rst_n_o=0xA5, set_n_o=0x5A.
  - k+4: rst_n_o=0xA7, set_n_o=0x5B.
  - k+5: 0xAF / 0x5F.
  - k+6: 0xBF / 0x7F.
  - k+7: 0xFF / 0xFF.
  - k+8: done=1, busy=0.
- Ignored start: re-pulse start with init_val=0x00 at k+2 → sequence and values are identical to the normal-init case.
- Abort: abort at k+5 → at k+5 rst_n_o=0x00, set_n_o=0xFF, state IDLE. A later start with 0x3C gives rst_n_o=0x3C, set_n_o=0xC3.
- Async reset mid-RELEASE: drop R between edges k+5 and k+6 → outputs go to 0x00/0xFF immediately, without waiting for a clock edge.
- Invariant check over all cycles with random start/abort/init_val: (~rst_n_o & ~set_n_o)==0 at all times. From DONE, restart with 0xFF → set_n_o=0x00 for 4 cycles, then the release sequence runs.

Source files
------------

// File: rtl/ff_init_pkg.sv
// Shared types and width helpers for the set/reset flop-bank init sequencer.
package ff_init_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    RELEASE,
    DONE
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // A counter that only ever holds 0 still needs one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (clog2(n) == 0) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/ff_init_cnt.sv
// Loadable down-counter that saturates at zero and flags it.
module ff_init_cnt #(
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ff_init_ctrl.sv
// Forces a programmable value onto a bank of set/reset flops, holds it, then
// releases the bank one group per cycle, LSB group first.
module ff_init_ctrl
  import ff_init_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GROUP = 2,
  parameter int unsigned HOLD  = 4
) (
  input  logic             clk,
  input  logic             R,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] init_val,
  output logic [WIDTH-1:0] rst_n_o,
  output logic [WIDTH-1:0] set_n_o,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NGRP = WIDTH / GROUP;
  localparam int unsigned HCW  = cnt_w(HOLD);
  localparam int unsigned GCW  = cnt_w(NGRP);
  localparam logic [WIDTH-1:0] GRP0_MASK = WIDTH'({GROUP{1'b1}});

  state_e           state_q, state_d;
  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] rel_q, rel_d;
  logic [WIDTH-1:0] rst_n_q, rst_n_d, set_n_q, set_n_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             hold_load, hold_dec, hold_zero;
  logic             grp_load, grp_dec, grp_zero;

  ff_init_cnt #(.W(HCW)) u_hold_cnt (
    .clk_i      (clk),
    .rst_n_i    (R),
    .load_i     (hold_load),
    .dec_i      (hold_dec),
    .load_val_i (HCW'(HOLD - 1)),
    .zero_o     (hold_zero)
  );

  ff_init_cnt #(.W(GCW)) u_grp_cnt (
    .clk_i      (clk),
    .rst_n_i    (R),
    .load_i     (grp_load),
    .dec_i      (grp_dec),
    .load_val_i (GCW'(NGRP - 1)),
    .zero_o     (grp_zero)
  );

  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    rel_d     = rel_q;
    hold_load = 1'b0;
    hold_dec  = 1'b0;
    grp_load  = 1'b0;
    grp_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = ASSERT;
          v_d       = init_val;
          hold_load = 1'b1;
        end
      end
      ASSERT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (hold_zero) begin
          state_d  = RELEASE;
          rel_d    = GRP0_MASK;
          grp_load = 1'b1;
        end else begin
          hold_dec = 1'b1;
        end
      end
      RELEASE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (grp_zero) begin
          state_d = DONE;
          rel_d   = '1;
        end else begin
          grp_dec = 1'b1;
          rel_d   = (rel_q << GROUP) | GRP0_MASK;
        end
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          state_d   = ASSERT;
          v_d       = init_val;
          hold_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE || state_d == ASSERT) rel_d = '0;

    // Outputs are decoded from the next state so they register on the same edge.
    rst_n_d = '0;
    set_n_d = '1;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      ASSERT, RELEASE: begin
        rst_n_d = v_d | rel_d;
        set_n_d = ~v_d | rel_d;
        busy_d  = 1'b1;
      end
      DONE: begin
        rst_n_d = '1;
        set_n_d = '1;
        done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q <= IDLE;
      v_q     <= '0;
      rel_q   <= '0;
      rst_n_q <= '0;
      set_n_q <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      rel_q   <= rel_d;
      rst_n_q <= rst_n_d;
      set_n_q <= set_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rst_n_o = rst_n_q;
  assign set_n_o = set_n_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_ff_init_ctrl.sv
// Directed bench for ff_init_ctrl with WIDTH=8, GROUP=2, HOLD=4.
module tb_ff_init_ctrl;

  logic       clk = 1'b0;
  logic       R, start, abort;
  logic [7:0] init_val, rst_n_o, set_n_o;
  logic       busy, done;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  ff_init_ctrl #(.WIDTH(8), .GROUP(2), .HOLD(4)) dut (
    .clk      (clk),
    .R        (R),
    .start    (start),
    .abort    (abort),
    .init_val (init_val),
    .rst_n_o  (rst_n_o),
    .set_n_o  (set_n_o),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    check({tag, ".rst_n"}, {24'd0, rst_n_o}, 32'h00);
    check({tag, ".set_n"}, {24'd0, set_n_o}, 32'hFF);
    check({tag, ".busy"},  {31'd0, busy},    32'd0);
    check({tag, ".done"},  {31'd0, done},    32'd0);
  endtask

  // Bits released once n groups of two have gone.
  function automatic logic [7:0] rel_mask(input int n);
    logic [15:0] m;
    m = (16'd1 << (2 * n)) - 16'd1;
    return m[7:0];
  endfunction

  // Start at edge k and check edges k..k+8; optionally re-pulse start at k+2.
  task automatic run_seq(input logic [7:0] v, input bit repulse);
    logic [7:0] m, er, es;
    init_val = v;
    start    = 1'b1;
    for (int j = 0; j < 9; j++) begin
      tick();
      start = repulse && (j == 1);
      if (start) init_val = 8'h00;
      m  = (j < 4) ? 8'h00 : rel_mask(j - 3);
      er = v | m;
      es = ~v | m;
      check($sformatf("v%02h k+%0d rst_n", v, j), {24'd0, rst_n_o}, {24'd0, er});
      check($sformatf("v%02h k+%0d set_n", v, j), {24'd0, set_n_o}, {24'd0, es});
      check($sformatf("v%02h k+%0d busy", v, j),  {31'd0, busy},    {31'd0, (j < 8)});
      check($sformatf("v%02h k+%0d done", v, j),  {31'd0, done},    {31'd0, (j == 8)});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] inv;
    R = 1'b1; start = 1'b0; abort = 1'b0; init_val = 8'h00;
    #1 R = 1'b0;
    #2 chk_idle("reset");
    @(posedge clk); #1 R = 1'b1;
    repeat (3) tick();
    chk_idle("idle_hold");

    run_seq(8'hA5, 1'b0);

    abort = 1'b1; tick(); abort = 1'b0;
    chk_idle("abort_in_done");

    run_seq(8'hA5, 1'b1);

    // Abort at k+5, mid-release; start in the same cycle must lose.
    init_val = 8'hA5; start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    check("abort_pre k+4 rst_n", {24'd0, rst_n_o}, 32'hA7);
    check("abort_pre k+4 set_n", {24'd0, set_n_o}, 32'h5B);
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    chk_idle("abort_k5");

    abort = 1'b1; start = 1'b1; init_val = 8'h3C; tick(); abort = 1'b0; start = 1'b0;
    chk_idle("idle_abort_blocks_start");
    tick();
    chk_idle("idle_after_block");

    run_seq(8'h3C, 1'b0);

    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    chk_idle("done_abort_priority");

    // Async reset between edges k+5 and k+6.
    init_val = 8'hA5; start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    check("arst_pre k+5 rst_n", {24'd0, rst_n_o}, 32'hAF);
    check("arst_pre k+5 set_n", {24'd0, set_n_o}, 32'h5F);
    #2 R = 1'b0;
    #1 chk_idle("async_reset");
    @(posedge clk); #1 chk_idle("async_reset_held");
    R = 1'b1;
    repeat (2) tick();
    chk_idle("after_async_reset");

    for (int c = 0; c < 300; c++) begin
      start    = ($urandom_range(0, 3) == 0);
      abort    = ($urandom_range(0, 15) == 0);
      R        = ($urandom_range(0, 31) != 0);
      init_val = 8'($urandom);
      tick();
      inv = ~rst_n_o & ~set_n_o;
      check("invariant_pos", {24'd0, inv}, 32'd0);
      @(negedge clk);
      inv = ~rst_n_o & ~set_n_o;
      check("invariant_neg", {24'd0, inv}, 32'd0);
    end
    R = 1'b1; start = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
    chk_idle("after_random");

    run_seq(8'hAA, 1'b0);
    run_seq(8'hFF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
